// File: rtl/demux_8ch_deserializer.sv
// -----------------------------------------------------------------------------
// demux_8ch_deserializer
//
// Rebuilds WORD_W-bit words from the serial bit stream of a 1-to-8 demux.
// Each channel has its own shift register (MSB first), bit counter and full
// flag. Completed words are handed round-robin to one valid/ready output slot
// tagged with the source channel.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   bit_valid  y/s carry a valid bit this cycle
//   y[7:0]     demux output bus; only lane y[s] is used
//   s[2:0]     channel select that steered the demux
//   out_valid  out_data/out_ch hold a completed word
//   out_ready  consumer accepts the word
//   out_data   assembled word (WORD_W bits)
//   out_ch     source channel of out_data
//   busy       any partial word, any full channel, or out_valid
//
// Optional build macro DESER_OVF_STATUS_EN adds:
//   ovf[7:0]   sticky per-channel dropped-bit flags
//   ovf_clr    synchronous clear of all ovf bits (a same-edge drop wins)
// -----------------------------------------------------------------------------
module demux_8ch_deserializer #(
    parameter int WORD_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bit_valid,
    input  logic [7:0]        y,
    input  logic [2:0]        s,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_data,
    output logic [2:0]        out_ch,
`ifdef DESER_OVF_STATUS_EN
    output logic [7:0]        ovf,
    input  logic              ovf_clr,
`endif
    output logic              busy
);

    localparam int               CNT_W    = $clog2(WORD_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_W - 1);

    logic [WORD_W-1:0] sr_q  [8];
    logic [WORD_W-1:0] sr_d  [8];
    logic [CNT_W-1:0]  cnt_q [8];
    logic [CNT_W-1:0]  cnt_d [8];
    logic [7:0]        full_q, full_d;
    logic [2:0]        last_grant_q, last_grant_d;

    logic              out_valid_q, out_valid_d;
    logic [WORD_W-1:0] out_data_q, out_data_d;
    logic [2:0]        out_ch_q, out_ch_d;

    logic              slot_load;
    logic              grant_vld;
    logic [2:0]        grant_ch;
    logic [2:0]        rr_idx;

`ifdef DESER_OVF_STATUS_EN
    logic [7:0]        drop;
    logic [7:0]        ovf_q, ovf_d;
`endif

    assign slot_load = !out_valid_q || out_ready;

    // Round-robin search starting just after the last granted channel; the
    // eighth step lands on last_grant itself so it has lowest priority.
    always_comb begin
        grant_vld = 1'b0;
        grant_ch  = last_grant_q;
        rr_idx    = last_grant_q;
        for (int i = 1; i <= 8; i++) begin
            rr_idx = last_grant_q + 3'(i);
            if (!grant_vld && full_q[rr_idx]) begin
                grant_vld = 1'b1;
                grant_ch  = rr_idx;
            end
        end
        if (!slot_load) begin
            grant_vld = 1'b0;
        end
    end

    // Per-channel assembly. A full channel still accepts a bit when it is
    // being granted on the same edge: its counter is already 0, so the bit
    // starts a fresh word while the output slot takes the pre-shift word.
    always_comb begin
        sr_d   = sr_q;
        cnt_d  = cnt_q;
        full_d = full_q;
`ifdef DESER_OVF_STATUS_EN
        drop   = 8'h00;
`endif
        if (grant_vld) begin
            full_d[grant_ch] = 1'b0;
        end
        if (bit_valid) begin
            if (!full_q[s] || (grant_vld && grant_ch == s)) begin
                sr_d[s] = {sr_q[s][WORD_W-2:0], y[s]};
                if (cnt_q[s] == CNT_LAST) begin
                    cnt_d[s]  = '0;
                    full_d[s] = 1'b1;
                end else begin
                    cnt_d[s] = cnt_q[s] + CNT_W'(1);
                end
            end else begin
`ifdef DESER_OVF_STATUS_EN
                drop[s] = 1'b1;
`endif
            end
        end
    end

    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_ch_d     = out_ch_q;
        last_grant_d = last_grant_q;
        if (grant_vld) begin
            out_valid_d  = 1'b1;
            out_data_d   = sr_q[grant_ch];
            out_ch_d     = grant_ch;
            last_grant_d = grant_ch;
        end else if (slot_load) begin
            out_valid_d = 1'b0;
        end
    end

`ifdef DESER_OVF_STATUS_EN
    always_comb begin
        ovf_d = ovf_clr ? 8'h00 : ovf_q;
        ovf_d = ovf_d | drop;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < 8; c++) begin
                sr_q[c]  <= '0;
                cnt_q[c] <= '0;
            end
            full_q       <= 8'h00;
            last_grant_q <= 3'd7;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_ch_q     <= 3'd0;
`ifdef DESER_OVF_STATUS_EN
            ovf_q        <= 8'h00;
`endif
        end else begin
            sr_q         <= sr_d;
            cnt_q        <= cnt_d;
            full_q       <= full_d;
            last_grant_q <= last_grant_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_ch_q     <= out_ch_d;
`ifdef DESER_OVF_STATUS_EN
            ovf_q        <= ovf_d;
`endif
        end
    end

    always_comb begin
        busy = out_valid_q | (|full_q);
        for (int c = 0; c < 8; c++) begin
            if (cnt_q[c] != '0) begin
                busy = 1'b1;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
`ifdef DESER_OVF_STATUS_EN
    assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_demux_8ch_deserializer.sv
module tb_demux_8ch_deserializer;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         bit_valid;
    logic [7:0]   y;
    logic [2:0]   s;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic [2:0]   out_ch;
    logic         busy;
`ifdef DESER_OVF_STATUS_EN
    logic [7:0]   ovf;
    logic         ovf_clr;
`endif

    int vectors     = 0;
    int miscompares = 0;
    bit chk_en      = 0;

    demux_8ch_deserializer #(.WORD_W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bit_valid (bit_valid),
        .y         (y),
        .s         (s),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ch    (out_ch),
`ifdef DESER_OVF_STATUS_EN
        .ovf       (ovf),
        .ovf_clr   (ovf_clr),
`endif
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- behavioural model ----------------
    // Words are accumulated arithmetically (val = 2*val + bit); a finished
    // word parks in done_word until it wins the round-robin.
    int  m_val  [8];
    int  m_n    [8];
    int  m_dw   [8];
    bit  m_done [8];
    bit  m_ov;
    int  m_data, m_ch, m_lg;
    bit  [7:0] m_ovf;
    int  mq_d[$], mq_c[$];
    int  dq_d[$], dq_c[$];

    always @(posedge clk or negedge rst_n) begin : model
        int  g, c, b;
        bit  load;
        if (!rst_n) begin
            for (int k = 0; k < 8; k++) begin
                m_val[k] = 0; m_n[k] = 0; m_dw[k] = 0; m_done[k] = 0;
            end
            m_ov = 0; m_data = 0; m_ch = 0; m_lg = 7; m_ovf = 8'h00;
        end else begin
            load = !m_ov || out_ready;
            if (m_ov && out_ready) begin
                mq_d.push_back(m_data);
                mq_c.push_back(m_ch);
            end
            g = -1;
            if (load)
                for (int i = 1; i <= 8; i++)
                    if (g < 0 && m_done[(m_lg + i) % 8]) g = (m_lg + i) % 8;
            if (g >= 0) begin
                m_data = m_dw[g]; m_ch = g; m_ov = 1; m_done[g] = 0; m_lg = g;
            end else if (load) begin
                m_ov = 0;
            end
`ifdef DESER_OVF_STATUS_EN
            if (ovf_clr) m_ovf = 8'h00;
`endif
            if (bit_valid) begin
                c = int'(s);
                b = int'(y[s]);
                if (!m_done[c]) begin
                    m_val[c] = m_val[c] * 2 + b;
                    m_n[c]   = m_n[c] + 1;
                    if (m_n[c] == W) begin
                        m_dw[c] = m_val[c]; m_done[c] = 1; m_val[c] = 0; m_n[c] = 0;
                    end
                end else begin
                    m_ovf[c] = 1'b1;
                end
            end
        end
    end

    // DUT transfers, recorded at the edge where they happen
    always @(posedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            dq_d.push_back(int'(out_data));
            dq_c.push_back(int'(out_ch));
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic bit model_busy();
        bit r;
        r = m_ov;
        for (int k = 0; k < 8; k++) if (m_n[k] != 0 || m_done[k]) r = 1;
        return r;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("out_valid", 32'(out_valid), 32'(m_ov));
            if (m_ov) begin
                chk("out_data", 32'(out_data), 32'(m_data));
                chk("out_ch", 32'(out_ch), 32'(m_ch));
            end
            chk("busy", 32'(busy), 32'(model_busy()));
`ifdef DESER_OVF_STATUS_EN
            chk("ovf", 32'(ovf), 32'(m_ovf));
`endif
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic send_bit(input int ch, input bit b, input bit clean);
        s = 3'(ch);
        y = clean ? 8'h00 : 8'($urandom);
        y[ch] = b;
        bit_valid = 1'b1;
        cyc();
        bit_valid = 1'b0;
        y = 8'($urandom);
    endtask

    task automatic send_word(input int ch, input logic [7:0] w, input bit clean);
        for (int i = 7; i >= 0; i--) send_bit(ch, w[i], clean);
    endtask

    task automatic send3(input int c0, input logic [7:0] w0, input int c1, input logic [7:0] w1,
                         input int c2, input logic [7:0] w2, input bit use3);
        for (int i = 7; i >= 0; i--) begin
            send_bit(c0, w0[i], 1'b0);
            send_bit(c1, w1[i], 1'b0);
            if (use3) send_bit(c2, w2[i], 1'b0);
        end
    endtask

    task automatic chk_log(input int idx, input int d, input int c);
        if (idx < dq_d.size()) begin
            chk($sformatf("dut_word%0d_data", idx), 32'(dq_d[idx]), 32'(d));
            chk($sformatf("dut_word%0d_ch", idx), 32'(dq_c[idx]), 32'(c));
        end else begin
            vectors++; miscompares++;
            $display("FAIL dut_word%0d: got none expected %0h/ch%0d", idx, d, c);
        end
        if (idx < mq_d.size()) begin
            chk($sformatf("model_word%0d_data", idx), 32'(mq_d[idx]), 32'(d));
            chk($sformatf("model_word%0d_ch", idx), 32'(mq_c[idx]), 32'(c));
        end else begin
            vectors++; miscompares++;
            $display("FAIL model_word%0d: got none expected %0h/ch%0d", idx, d, c);
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst_n = 1'b0; bit_valid = 1'b0; y = 8'h00; s = 3'd0; out_ready = 1'b1;
`ifdef DESER_OVF_STATUS_EN
        ovf_clr = 1'b0;
`endif
        idle(3);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        rst_n = 1'b1;
        chk_en = 1;
        idle(2);

        // ch3 0xA5, clean lanes
        send_word(3, 8'hA5, 1'b1);
        chk("a5_full_not_yet_valid", 32'(out_valid), 32'd0);
        chk("a5_busy_while_full", 32'(busy), 32'd1);
        cyc();
        chk("a5_valid", 32'(out_valid), 32'd1);
        chk("a5_data", 32'(out_data), 32'hA5);
        chk("a5_ch", 32'(out_ch), 32'd3);
        idle(2);
        chk("a5_busy_after", 32'(busy), 32'd0);

        // three channels full together behind a ch7 word; drain 0,5,7
        out_ready = 1'b0;
        send_word(7, 8'hE7, 1'b0);
        send3(0, 8'h11, 5, 8'h55, 7, 8'h77, 1'b1);
        idle(2);
        out_ready = 1'b1;
        idle(6);
        // again with last_grant=7: ch0 must come before ch5
        out_ready = 1'b0;
        send_word(7, 8'h3E, 1'b0);
        send3(5, 8'hC5, 0, 8'h0C, 0, 8'h00, 1'b0);
        idle(2);
        out_ready = 1'b1;
        idle(5);

        // backpressure, ch1 0x3C held for 10 cycles
        out_ready = 1'b0;
        send_word(1, 8'h3C, 1'b0);
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_data", 32'(out_data), 32'h3C);
            chk("bp_ch", 32'(out_ch), 32'd1);
        end
        out_ready = 1'b1;
        cyc();
        chk("bp_released", 32'(out_valid), 32'd0);
        idle(2);

        // overflow on ch2
        out_ready = 1'b0;
        send_word(2, 8'hF0, 1'b0);
        send_word(2, 8'h0F, 1'b0);
        send_bit(2, 1'b1, 1'b0);
        send_bit(2, 1'b1, 1'b0);
        send_bit(2, 1'b0, 1'b0);
`ifdef DESER_OVF_STATUS_EN
        chk("ovf_set", 32'(ovf), 32'h04);
        ovf_clr = 1'b1;
        send_bit(2, 1'b1, 1'b0);
        ovf_clr = 1'b0;
        chk("ovf_set_beats_clr", 32'(ovf), 32'h04);
        ovf_clr = 1'b1;
        cyc();
        ovf_clr = 1'b0;
        chk("ovf_cleared", 32'(ovf), 32'h00);
`else
        send_bit(2, 1'b1, 1'b0);
`endif
        chk("ovf_slot_data", 32'(out_data), 32'hF0);
        out_ready = 1'b1;
        idle(4);

        // grant/accept collision on ch4
        send_word(4, 8'h5A, 1'b0);
        send_word(4, 8'hC3, 1'b0);
        idle(3);

        // reset mid-word with a word held in the slot
        out_ready = 1'b0;
        send_word(3, 8'h99, 1'b0);
        send_bit(6, 1'b1, 1'b0);
        send_bit(6, 1'b0, 1'b0);
        send_bit(6, 1'b1, 1'b0);
        send_bit(6, 1'b1, 1'b0);
        send_bit(6, 1'b0, 1'b0);
        chk("pre_rst_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_data", 32'(out_data), 32'd0);
        chk("mid_rst_ch", 32'(out_ch), 32'd0);
        cyc();
        rst_n = 1'b1;
        out_ready = 1'b1;
        idle(1);
        send_word(6, 8'h81, 1'b0);
        idle(3);

        chk_log(0,  'hA5, 3);
        chk_log(1,  'hE7, 7);
        chk_log(2,  'h11, 0);
        chk_log(3,  'h55, 5);
        chk_log(4,  'h77, 7);
        chk_log(5,  'h3E, 7);
        chk_log(6,  'h0C, 0);
        chk_log(7,  'hC5, 5);
        chk_log(8,  'h3C, 1);
        chk_log(9,  'hF0, 2);
        chk_log(10, 'h0F, 2);
        chk_log(11, 'h5A, 4);
        chk_log(12, 'hC3, 4);
        chk_log(13, 'h81, 6);
        chk("dut_word_count", 32'(dq_d.size()), 32'd14);
        chk("final_busy", 32'(busy), 32'd0);

        chk_en = 0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
